// File: rtl/evm_pkg.sv
// Shared types and constants for the voter-side ballot unit.
package evm_pkg;

   localparam int unsigned NUM_PARTIES = 4;

   localparam logic [NUM_PARTIES-1:0] PARTY1 = 4'b0001;
   localparam logic [NUM_PARTIES-1:0] PARTY2 = 4'b0010;
   localparam logic [NUM_PARTIES-1:0] PARTY3 = 4'b0100;
   localparam logic [NUM_PARTIES-1:0] PARTY4 = 4'b1000;

   localparam logic [6:0] BALLOTS_MAX = 7'd127;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      DEBOUNCE,
      SETUP,
      PULSE,
      HOLD,
      RELEASE
   } ballot_state_t;

   function automatic logic is_onehot4(input logic [NUM_PARTIES-1:0] k);
      return k inside {PARTY1, PARTY2, PARTY3, PARTY4};
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop key synchroniser plus a stability counter on the synchronised vector.
module key_debounce
   import evm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic [NUM_PARTIES-1:0] party_key,
   output logic [NUM_PARTIES-1:0] key_sync,
   output logic [NUM_PARTIES-1:0] key_stable,
   output logic                   stable
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_PARTIES-1:0] sync_meta;
   logic [CW-1:0]          cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta  <= '0;
         key_sync   <= '0;
         key_stable <= '0;
         cnt        <= '0;
      end else begin
         sync_meta <= party_key;
         key_sync  <= sync_meta;
         // any change (or an explicit restart) reloads the reference and restarts the count
         if (clear || (key_sync != key_stable)) begin
            key_stable <= key_sync;
            cnt        <= '0;
         end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign stable = (cnt == CNT_LAST) && (key_sync == key_stable);

endmodule

// File: rtl/ballot_unit.sv
// Ballot unit: arms one ballot per issue, debounces party keys, emits one-hot select plus push strobe.
module ballot_unit
   import evm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1000
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ballot_issue,
   input  logic                   voting_en,
   input  logic [NUM_PARTIES-1:0] party_key,
   output logic [NUM_PARTIES-1:0] voter_switch,
   output logic                   push_button,
   output logic                   ballot_ready,
   output logic                   vote_done,
   output logic                   invalid_key,
   output logic                   ballot_timeout,
   output logic [6:0]             ballots_cast
);

   localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   ballot_state_t          state_q, state_d;
   logic                   owed_q, owed_d;
   logic [NUM_PARTIES-1:0] sel_q, sel_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [PW-1:0]          pcnt_q, pcnt_d;
   logic [NUM_PARTIES-1:0] vs_d;
   logic                   pb_d, rdy_d, done_d, inv_d, to_d;
   logic [6:0]             cast_d;

   logic                   deb_clear;
   logic [NUM_PARTIES-1:0] key_sync, key_stable;
   logic                   stable;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (deb_clear),
      .party_key (party_key),
      .key_sync  (key_sync),
      .key_stable(key_stable),
      .stable    (stable)
   );

   always_comb begin
      state_d   = state_q;
      owed_d    = owed_q;
      sel_d     = sel_q;
      tcnt_d    = tcnt_q;
      pcnt_d    = pcnt_q;
      cast_d    = ballots_cast;
      done_d    = 1'b0;
      inv_d     = 1'b0;
      to_d      = 1'b0;
      deb_clear = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ballot_issue && voting_en) begin
               state_d = ARMED;
               tcnt_d  = '0;
            end
         end
         ARMED: begin
            // holding clear here latches the very sample that triggers DEBOUNCE
            deb_clear = 1'b1;
            if (!voting_en) begin
               state_d = IDLE;
            end else if (key_sync != '0) begin
               state_d = DEBOUNCE;
            end else if (tcnt_q == T_LAST) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         DEBOUNCE: begin
            if (!voting_en) begin
               state_d = IDLE;
            end else if (stable) begin
               if (key_stable == '0) begin
                  state_d = ARMED;
               end else if (is_onehot4(key_stable)) begin
                  sel_d   = key_stable;
                  state_d = SETUP;
               end else begin
                  inv_d     = 1'b1;
                  owed_d    = 1'b1;
                  deb_clear = 1'b1;
                  state_d   = RELEASE;
               end
            end
         end
         SETUP: begin
            pcnt_d  = '0;
            state_d = PULSE;
         end
         PULSE: begin
            if (pcnt_q == P_LAST) state_d = HOLD;
            else                  pcnt_d  = pcnt_q + PW'(1);
         end
         HOLD: begin
            done_d    = 1'b1;
            owed_d    = 1'b0;
            deb_clear = 1'b1;
            if (ballots_cast != BALLOTS_MAX) cast_d = ballots_cast + 7'd1;
            state_d = RELEASE;
         end
         RELEASE: begin
            if (stable && (key_stable == '0)) begin
               if (owed_q) begin
                  owed_d  = 1'b0;
                  tcnt_d  = '0;
                  state_d = ARMED;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      vs_d  = (state_d inside {SETUP, PULSE, HOLD}) ? sel_d : '0;
      pb_d  = (state_d == PULSE);
      rdy_d = (state_d == ARMED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         owed_q         <= 1'b0;
         sel_q          <= '0;
         tcnt_q         <= '0;
         pcnt_q         <= '0;
         voter_switch   <= '0;
         push_button    <= 1'b0;
         ballot_ready   <= 1'b0;
         vote_done      <= 1'b0;
         invalid_key    <= 1'b0;
         ballot_timeout <= 1'b0;
         ballots_cast   <= '0;
      end else begin
         state_q        <= state_d;
         owed_q         <= owed_d;
         sel_q          <= sel_d;
         tcnt_q         <= tcnt_d;
         pcnt_q         <= pcnt_d;
         voter_switch   <= vs_d;
         push_button    <= pb_d;
         ballot_ready   <= rdy_d;
         vote_done      <= done_d;
         invalid_key    <= inv_d;
         ballot_timeout <= to_d;
         ballots_cast   <= cast_d;
      end
   end

endmodule

// File: tb/tb_ballot_unit.sv
// Self-checking bench for ballot_unit: randomized votes against an event-level model.
module tb_ballot_unit;

   localparam int unsigned DEB = 16;
   localparam int unsigned PUL = 4;
   localparam int unsigned TMO = 1000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ballot_issue = 1'b0;
   logic       voting_en = 1'b0;
   logic [3:0] party_key = 4'b0;
   logic [3:0] voter_switch;
   logic       push_button, ballot_ready, vote_done, invalid_key, ballot_timeout;
   logic [6:0] ballots_cast;

   int vectors = 0;
   int miscompares = 0;
   int exp_cast = 0;

   int rises = 0, dones = 0, invs = 0, tos = 0, badsel = 0, glitches = 0;
   int cur_w = 0, last_w = 0;
   logic       pb_prev = 1'b0;
   logic [3:0] vs_prev = 4'b0, vs_before = 4'b0, vs_pulse = 4'b0, vs_after = 4'b0;

   ballot_unit #(
      .DEBOUNCE_CYCLES(DEB),
      .PULSE_CYCLES   (PUL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ballot_issue  (ballot_issue),
      .voting_en     (voting_en),
      .party_key     (party_key),
      .voter_switch  (voter_switch),
      .push_button   (push_button),
      .ballot_ready  (ballot_ready),
      .vote_done     (vote_done),
      .invalid_key   (invalid_key),
      .ballot_timeout(ballot_timeout),
      .ballots_cast  (ballots_cast)
   );

   always #5 clk = ~clk;

   // event observer: records strobe shape and pulse counts as seen by the counting module
   always @(negedge clk) begin
      if (push_button && !pb_prev) begin
         rises++;
         vs_before = vs_prev;
         vs_pulse  = voter_switch;
         cur_w     = 0;
      end
      if (push_button) begin
         cur_w++;
         if (voter_switch !== vs_pulse) glitches++;
      end
      if (!push_button && pb_prev) begin
         last_w   = cur_w;
         vs_after = voter_switch;
      end
      if (vote_done === 1'b1)      dones++;
      if (invalid_key === 1'b1)    invs++;
      if (ballot_timeout === 1'b1) tos++;
      if (!$onehot0(voter_switch)) badsel++;
      pb_prev = push_button;
      vs_prev = voter_switch;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue();
      ballot_issue = 1'b1;
      tick();
      ballot_issue = 1'b0;
   endtask

   function automatic logic [3:0] rand_onehot();
      logic [3:0] k;
      k = 4'b0001 << $urandom_range(0, 3);
      return k;
   endfunction

   // drives one complete ballot; ok reports whether vote_done appeared within budget
   task automatic cast_vote(input logic [3:0] key, input int per, output bit ok);
      int d0;
      ok = 1'b0;
      d0 = dones;
      issue();
      if (per > 0)
         for (int i = 0; i < 40; i++) begin
            party_key = (((i / per) % 2) == 0) ? key : 4'b0;
            tick();
         end
      party_key = key;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (dones != d0) ok = 1'b1;
      end
      party_key = 4'b0;
      repeat (DEB + 10) tick();
      if (exp_cast < 127) exp_cast++;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      if (voter_switch !== 4'b0) begin miscompares++; $display("FAIL reset_vs: got %b want 0000", voter_switch); end
      vectors++;
      if (push_button !== 1'b0) begin miscompares++; $display("FAIL reset_pb: got %b want 0", push_button); end
      vectors++;
      if (ballot_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ballot_ready); end
      vectors++;
      if ({vote_done, invalid_key, ballot_timeout} !== 3'b000) begin
         miscompares++; $display("FAIL reset_pulses: got %b want 000", {vote_done, invalid_key, ballot_timeout});
      end
      vectors++;
      if (ballots_cast !== 7'd0) begin miscompares++; $display("FAIL reset_cast: got %0d want 0", ballots_cast); end
      vectors++;
      reset_n = 1'b1;
      repeat (2) tick();
      if (ballot_ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready: got %b want 0", ballot_ready); end
      vectors++;
   endtask

   task automatic test_basic_vote();
      logic [3:0] key;
      bit ok;
      int r0;
      voting_en = 1'b1;
      for (int n = 0; n < 4; n++) begin
         key = (n == 0) ? 4'b0100 : rand_onehot();
         r0 = rises;
         cast_vote(key, 0, ok);
         if (!ok) begin miscompares++; $display("FAIL basic_done: vote_done not seen, key %b", key); end
         vectors++;
         if (rises !== r0 + 1) begin miscompares++; $display("FAIL basic_pulses: got %0d want %0d", rises - r0, 1); end
         vectors++;
         if (last_w !== PUL) begin miscompares++; $display("FAIL basic_width: got %0d want %0d", last_w, PUL); end
         vectors++;
         if (vs_before !== key) begin miscompares++; $display("FAIL basic_setup_vs: got %b want %b", vs_before, key); end
         vectors++;
         if (vs_pulse !== key) begin miscompares++; $display("FAIL basic_pulse_vs: got %b want %b", vs_pulse, key); end
         vectors++;
         if (vs_after !== key) begin miscompares++; $display("FAIL basic_hold_vs: got %b want %b", vs_after, key); end
         vectors++;
         if (ballots_cast !== 7'(exp_cast)) begin miscompares++; $display("FAIL basic_cast: got %0d want %0d", ballots_cast, exp_cast); end
         vectors++;
         if (voter_switch !== 4'b0) begin miscompares++; $display("FAIL basic_idle_vs: got %b want 0000", voter_switch); end
         vectors++;
      end
      if (glitches !== 0) begin miscompares++; $display("FAIL basic_glitch: got %0d want 0", glitches); end
      vectors++;
   endtask

   task automatic test_bounce();
      logic [3:0] key;
      bit ok;
      int r0, per;
      for (int n = 0; n < 3; n++) begin
         key = (n == 0) ? 4'b0001 : rand_onehot();
         per = (n == 0) ? 3 : int'($urandom_range(1, 5));
         r0 = rises;
         cast_vote(key, per, ok);
         if (!ok) begin miscompares++; $display("FAIL bounce_done: vote_done not seen, key %b", key); end
         vectors++;
         if (rises !== r0 + 1) begin miscompares++; $display("FAIL bounce_pulses: got %0d want 1", rises - r0); end
         vectors++;
         if (vs_pulse !== key) begin miscompares++; $display("FAIL bounce_vs: got %b want %b", vs_pulse, key); end
         vectors++;
         if (ballots_cast !== 7'(exp_cast)) begin miscompares++; $display("FAIL bounce_cast: got %0d want %0d", ballots_cast, exp_cast); end
         vectors++;
      end
   endtask

   task automatic test_multikey();
      int r0, i0, d0;
      bit ok;
      r0 = rises; i0 = invs; d0 = dones; ok = 1'b0;
      issue();
      party_key = 4'b0011;
      repeat (40) tick();
      if (invs !== i0 + 1) begin miscompares++; $display("FAIL multi_invalid: got %0d want 1", invs - i0); end
      vectors++;
      if (rises !== r0) begin miscompares++; $display("FAIL multi_nopulse: got %0d want 0", rises - r0); end
      vectors++;
      party_key = 4'b0;
      repeat (DEB + 10) tick();
      if (ballot_ready !== 1'b1) begin miscompares++; $display("FAIL multi_rearm: got %b want 1", ballot_ready); end
      vectors++;
      party_key = 4'b1000;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (dones != d0) ok = 1'b1;
      end
      party_key = 4'b0;
      repeat (DEB + 10) tick();
      exp_cast++;
      if (!ok || rises !== r0 + 1) begin miscompares++; $display("FAIL multi_vote: got %0d pulses want 1", rises - r0); end
      vectors++;
      if (vs_pulse !== 4'b1000) begin miscompares++; $display("FAIL multi_vs: got %b want 1000", vs_pulse); end
      vectors++;
      if (invs !== i0 + 1) begin miscompares++; $display("FAIL multi_invalid_once: got %0d want 1", invs - i0); end
      vectors++;
      if (ballots_cast !== 7'(exp_cast)) begin miscompares++; $display("FAIL multi_cast: got %0d want %0d", ballots_cast, exp_cast); end
      vectors++;
   endtask

   task automatic test_lockout();
      logic [3:0] k1, k2;
      int r0, d0;
      bit ok;
      k1 = rand_onehot();
      k2 = {k1[2:0], k1[3]};
      r0 = rises; d0 = dones; ok = 1'b0;
      issue();
      party_key = k1;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (dones != d0) ok = 1'b1;
      end
      exp_cast++;
      party_key = k1 | k2;
      repeat (30) tick();
      party_key = k2;
      repeat (30) tick();
      if (rises !== r0 + 1) begin miscompares++; $display("FAIL lock_pulses: got %0d want 1", rises - r0); end
      vectors++;
      if (ballot_ready !== 1'b0) begin miscompares++; $display("FAIL lock_ready: got %b want 0", ballot_ready); end
      vectors++;
      party_key = 4'b0;
      repeat (DEB + 10) tick();
      if (ballot_ready !== 1'b0) begin miscompares++; $display("FAIL lock_idle: got %b want 0", ballot_ready); end
      vectors++;
      if (ballots_cast !== 7'(exp_cast)) begin miscompares++; $display("FAIL lock_cast: got %0d want %0d", ballots_cast, exp_cast); end
      vectors++;
   endtask

   task automatic test_timeout_disable();
      int t0, r0;
      t0 = tos; r0 = rises;
      if (ballot_ready !== 1'b0) begin miscompares++; $display("FAIL to_pre_ready: got %b want 0", ballot_ready); end
      vectors++;
      issue();
      if (ballot_ready !== 1'b1) begin miscompares++; $display("FAIL to_ready_rise: got %b want 1", ballot_ready); end
      vectors++;
      repeat (TMO + 10) tick();
      if (tos !== t0 + 1) begin miscompares++; $display("FAIL to_pulse: got %0d want 1", tos - t0); end
      vectors++;
      if (ballot_ready !== 1'b0 || rises !== r0) begin
         miscompares++; $display("FAIL to_idle: got ready %b pulses %0d want 0 0", ballot_ready, rises - r0);
      end
      vectors++;
      voting_en = 1'b0;
      issue();
      repeat (3) tick();
      if (ballot_ready !== 1'b0) begin miscompares++; $display("FAIL dis_ready: got %b want 0", ballot_ready); end
      vectors++;
      voting_en = 1'b1;
      issue();
      repeat (5) tick();
      voting_en = 1'b0;
      repeat (2) tick();
      if (ballot_ready !== 1'b0) begin miscompares++; $display("FAIL cancel_ready: got %b want 0", ballot_ready); end
      vectors++;
      voting_en = 1'b1;
      repeat (TMO + 10) tick();
      if (tos !== t0 + 1) begin miscompares++; $display("FAIL cancel_notimeout: got %0d want 1", tos - t0); end
      vectors++;
   endtask

   task automatic test_reset_mid_pulse();
      bit found;
      found = 1'b0;
      issue();
      party_key = rand_onehot();
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (push_button === 1'b1) found = 1'b1;
      end
      #2;
      reset_n = 1'b0;
      #1;
      exp_cast = 0;
      if (!found) begin miscompares++; $display("FAIL rst_pulse_seen: got no push_button within budget"); end
      vectors++;
      if (push_button !== 1'b0) begin miscompares++; $display("FAIL rst_async_pb: got %b want 0", push_button); end
      vectors++;
      if (voter_switch !== 4'b0) begin miscompares++; $display("FAIL rst_async_vs: got %b want 0000", voter_switch); end
      vectors++;
      if (ballots_cast !== 7'd0) begin miscompares++; $display("FAIL rst_cast: got %0d want 0", ballots_cast); end
      vectors++;
      party_key = 4'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_saturation();
      int r0, nfail;
      bit ok;
      r0 = rises; nfail = 0;
      for (int n = 0; n < 128; n++) begin
         cast_vote(rand_onehot(), 0, ok);
         if (!ok) nfail++;
         if (n == 125 && ballots_cast !== 7'(exp_cast)) begin
            miscompares++; $display("FAIL sat_126: got %0d want %0d", ballots_cast, exp_cast);
         end
      end
      vectors++;
      if (nfail !== 0) begin miscompares++; $display("FAIL sat_done: got %0d incomplete votes want 0", nfail); end
      vectors++;
      if (ballots_cast !== 7'(exp_cast)) begin miscompares++; $display("FAIL sat_cast: got %0d want %0d", ballots_cast, exp_cast); end
      vectors++;
      if (rises !== r0 + 128) begin miscompares++; $display("FAIL sat_pulses: got %0d want 128", rises - r0); end
      vectors++;
      if (badsel !== 0 || glitches !== 0) begin
         miscompares++; $display("FAIL select_integrity: got %0d non-onehot %0d glitches want 0 0", badsel, glitches);
      end
      vectors++;
   endtask

   initial begin
      test_reset();
      test_basic_vote();
      test_bounce();
      test_multikey();
      test_lockout();
      test_timeout_disable();
      test_reset_mid_pulse();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
      $fatal(1);
   end

endmodule
